uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- UART transmitter; the sending end of the receiver's frame format.
- Serialises one frame: 1 start bit, DATA_BITS data bits (LSB first), 1 parity bit, 1 stop bit.
- Sits between the host/controller logic and the serial line, and drives the idle-high tx line.
- Contains its own bit-period counter, so no external baud tick is needed.

Parameters:
- CLK_DIV, 5208, clk cycles per bit period (50 MHz / 9600 baud). Must be >= 2.
- DATA_BITS, 7, data bits per frame (1..8).
- PARITY_ODD, 0, parity mode: 0 = even parity, 1 = odd parity.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to send data_in; sampled on every rising clk edge.
- data_in  input  DATA_BITS  payload; captured only in the cycle start is accepted.
- ready  output  1  high when a start request will be accepted (IDLE state).
- busy  output  1  high while a frame is being shifted out.
- tx  output  1  serial line output, registered; idle level is 1.
- done  output  1  one-cycle pulse when a frame has completed.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, tx=1, ready=1, busy=0, done=0. All counters and the shift register are cleared.
- Reset mid-frame: the frame is aborted and tx returns to 1 at once. No done pulse is produced.
- State machine: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- IDLE:
  - ready=1, busy=0, tx=1.
  - start=1 is accepted on a rising edge in IDLE. On that edge:
    - data_in is latched into the shift register.
    - The parity bit is computed and latched: XOR-reduction of data_in, inverted when PARITY_ODD=1.
    - The bit counter is cleared and the state moves to START.
- START: tx=0 for exactly CLK_DIV cycles, starting the cycle after acceptance (1-cycle latency).
- DATA:
  - tx = shift register bit 0 for CLK_DIV cycles.
  - At the end of each bit period the register shifts right and the bit index increments.
  - After bit index DATA_BITS-1 completes, the state moves to PARITY.
- PARITY: tx = latched parity bit for CLK_DIV cycles.
- STOP: tx=1 for CLK_DIV cycles, then the state moves to IDLE.
- Bit-period counter:
  - Width is $clog2(CLK_DIV).
  - Counts 0..CLK_DIV-1. The terminal count advances the state or bit and wraps to 0.
- Frame timing: total duration is (DATA_BITS+3)*CLK_DIV cycles, from the first tx=0 cycle to the last stop-bit cycle inclusive.
- done:
  - High for exactly the first cycle back in IDLE after STOP.
  - ready is also high in that cycle.
  - start asserted in that cycle is accepted, giving back-to-back frames with no extra idle bit.
- start while not IDLE: ignored, with no queuing. data_in changes during a frame do not affect it.
- busy = !ready at all times. ready and busy are never both high.
- Parity with all-zero data: even parity sends parity bit 0; odd parity sends 1.
- tx is glitch-free: driven straight from a flop, with no combinational path from start or data_in.

Test Plan:
- Reset release with no start; hold 100 cycles -> tx=1, ready=1, busy=0, done=0 throughout.
- CLK_DIV=4, DATA_BITS=7, even parity, start 1 cycle with data_in=7'h41:
  - tx per 4-cycle bit is 0,1,0,0,0,0,0,1,0,1 (parity 0).
  - busy high for 40 cycles.
  - done pulses 1 cycle at cycle 41 after acceptance.
- PARITY_ODD=1, data_in=7'h7F -> data bits all 1, parity bit 0, stop bit 1. Repeat with data_in=7'h00 -> parity bit 1.
- Start pulsed mid-frame with data_in=7'h55 while sending 7'h41 -> the frame is unchanged and no second frame follows.
- Reset asserted during data bit 3:
  - tx=1, ready=1, no done pulse.
  - Then a fresh start with 7'h2A transmits a complete, correct frame.
- Back-to-back: start held high continuously with data 7'h01 then 7'h02 -> the second start bit begins the cycle after the first stop bit ends, with no extra idle bit.

Source files
------------

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//
// UART transmitter. It serialises one frame per accepted request:
//   1 start bit (0), DATA_BITS data bits LSB first, 1 parity bit, 1 stop bit (1).
// The bit period comes from an internal counter, so no external baud tick is
// needed. All outputs come straight from flops, so tx cannot glitch.
//
// Parameters
//   CLK_DIV     clk cycles per bit period (>= 2)
//   DATA_BITS   data bits per frame (1..8)
//   PARITY_ODD  0 = even parity, 1 = odd parity
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   start    in   send request, accepted only while ready is high
//   data_in  in   payload, captured in the accepting cycle only
//   ready    out  high in IDLE, when a start request will be accepted
//   busy     out  high while a frame is being shifted out (always !ready)
//   tx       out  serial line, idle high
//   done     out  one-cycle pulse in the first IDLE cycle after a stop bit
// -----------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int CLK_DIV    = 5208,
    parameter int DATA_BITS  = 7,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 ready,
    output logic                 busy,
    output logic                 tx,
    output logic                 done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             PAR_INV  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity bit for a payload: XOR of all bits, inverted for odd parity.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d,
                                        input logic                 odd);
        return (^d) ^ odd;
    endfunction

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic [IDX_W-1:0]       idx_q,   idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q,   par_d;
    logic                   tx_q,    tx_d;
    logic                   ready_q, ready_d;
    logic                   busy_q,  busy_d;
    logic                   done_q,  done_d;
    logic                   bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_START;
                    shreg_d = data_in;
                    par_d   = parity_bit(data_in, PAR_INV);
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = '0;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    // Shift after every data bit; the parity bit does not
                    // come from the shift register, so the last shift is harmless.
                    shreg_d = shreg_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_PARITY;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            ST_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so that the registered
        // copies line up with the state they describe.
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = par_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase

        ready_d = (state_d == ST_IDLE) ? 1'b1 : 1'b0;
        busy_d  = ~ready_d;
    end

    // State machine, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// Bench for uart_tx_frame. Two instances share all inputs: one with even
// parity, one with odd parity. Expected line levels come from a frame model
// that maps "cycle k after acceptance" to a bit position in the frame.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

    localparam int CLK_DIV    = 4;
    localparam int DATA_BITS  = 7;
    localparam int FRAME_BITS = DATA_BITS + 3;
    localparam int FRAME_CYC  = FRAME_BITS * CLK_DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] data_in;

    logic ready_e, busy_e, tx_e, done_e;
    logic ready_o, busy_o, tx_o, done_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .PARITY_ODD(0)) dut_even (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .ready(ready_e), .busy(busy_e), .tx(tx_e), .done(done_e)
    );

    uart_tx_frame #(.CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .ready(ready_o), .busy(busy_o), .tx(tx_o), .done(done_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Line level k cycles after acceptance (k = 1..FRAME_CYC).
    function automatic logic model_line(input logic [6:0] d, input bit odd, input int k);
        int b;
        b = (k - 1) / CLK_DIV;
        if (b == 0)                return 1'b0;
        else if (b <= DATA_BITS)   return d[b-1];
        else if (b == DATA_BITS+1) return (^d) ^ odd;
        else                       return 1'b1;
    endfunction

    // Idle expectation for both instances: {tx, ready, busy, done} = 1,1,0,0.
    task automatic check_idle(input string tag);
        check_val({tag, " even"}, 32'({tx_e, ready_e, busy_e, done_e}), 32'(4'b1100));
        check_val({tag, " odd"},  32'({tx_o, ready_o, busy_o, done_o}), 32'(4'b1100));
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_idle(tag);
            start   = 1'b0;
            data_in = 7'($urandom);
        end
    endtask

    // Sends one frame from a negedge where the DUT is ready. inj_k > 0 pulses
    // start with inj_d during cycle inj_k; hold keeps start high throughout.
    // Returns at the negedge of the done cycle, so a following call is
    // back-to-back.
    task automatic send_frame(input logic [6:0] d, input int inj_k,
                              input logic [6:0] inj_d, input bit hold);
        logic [3:0] exp_e;
        logic [3:0] exp_o;
        check_val("ready_before_start", 32'({ready_e, ready_o}), 32'(2'b11));
        start   = 1'b1;
        data_in = d;
        for (int k = 1; k <= FRAME_CYC + 1; k++) begin
            @(negedge clk);
            if (k <= FRAME_CYC) begin
                exp_e = {model_line(d, 1'b0, k), 3'b010};
                exp_o = {model_line(d, 1'b1, k), 3'b010};
            end else begin
                exp_e = 4'b1101;
                exp_o = 4'b1101;
            end
            check_val($sformatf("frame %02h k=%0d even", d, k), 32'({tx_e, ready_e, busy_e, done_e}), 32'(exp_e));
            check_val($sformatf("frame %02h k=%0d odd",  d, k), 32'({tx_o, ready_o, busy_o, done_o}), 32'(exp_o));
            if (k <= FRAME_CYC && hold) begin
                start   = 1'b1;
                data_in = d;
            end else if (k <= FRAME_CYC && k == inj_k) begin
                start   = 1'b1;
                data_in = inj_d;
            end else begin
                start   = 1'b0;
                data_in = 7'($urandom);
            end
        end
    endtask

    initial begin
        int gap;
        int inj;
        bit hold;
        logic [6:0] d;

        reset   = 1'b1;
        start   = 1'b0;
        data_in = 7'h00;
        repeat (3) @(negedge clk);
        check_idle("in_reset");
        reset = 1'b0;
        idle_cycles(100, "idle_after_reset");

        // Directed frames.
        send_frame(7'h41, 0, 7'h00, 1'b0);
        idle_cycles(5, "idle_after_41");
        send_frame(7'h7F, 0, 7'h00, 1'b0);
        idle_cycles(3, "idle_after_7f");
        send_frame(7'h00, 0, 7'h00, 1'b0);
        idle_cycles(3, "idle_after_00");

        // Start mid-frame is ignored and nothing is queued.
        send_frame(7'h41, 10, 7'h55, 1'b0);
        idle_cycles(60, "no_queued_frame");

        // Reset during data bit 3 (cycles 17..20 after acceptance).
        start   = 1'b1;
        data_in = 7'h41;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            start   = 1'b0;
            data_in = 7'($urandom);
            check_val($sformatf("pre_abort k=%0d", k), 32'({tx_e, tx_o}),
                      32'({model_line(7'h41, 1'b0, k), model_line(7'h41, 1'b1, k)}));
        end
        reset = 1'b1;
        #1;
        check_idle("abort_immediate");
        repeat (2) @(negedge clk);
        check_idle("abort_held");
        reset = 1'b0;
        idle_cycles(50, "after_abort");
        send_frame(7'h2A, 0, 7'h00, 1'b0);
        idle_cycles(3, "idle_after_2a");

        // Back-to-back with start held high.
        send_frame(7'h01, 0, 7'h00, 1'b1);
        send_frame(7'h02, 0, 7'h00, 1'b0);
        idle_cycles(10, "idle_after_b2b");

        // Randomised frames, injections (including the last busy cycle) and gaps.
        for (int n = 0; n < 25; n++) begin
            d    = 7'($urandom);
            inj  = $urandom_range(0, FRAME_CYC);
            hold = ($urandom_range(0, 9) == 0);
            gap  = $urandom_range(0, 3);
            send_frame(d, inj, 7'($urandom), hold);
            if (gap > 0) idle_cycles(gap, "rand_gap");
        end
        idle_cycles(50, "final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
